// File: rtl/datapath_regs.sv
// datapath_regs: processor datapath register file with a shared 16-bit bus.
//   clk, rst_n                   : clock, async active-low reset
//   write_en/inc_en/clr_en[15:0] : per-target load / increment / clear strobes
//   read_en[3:0]                 : bus source select code
//   alu_out, dm_rdata, im_rdata  : datapath sources
//   bus                          : combinational shared bus
//   pc, ar, ir, ac, r, r1..r4    : register contents
//   z                            : 16'd1 when ac == 0
//   dm_we, dm_addr, dm_wdata     : data-memory write port (combinational)
//   im_addr                      : instruction-memory address (combinational)
// Optional feature: define DATAPATH_R5_EN to implement register R5.
module datapath_regs (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] write_en,
  input  logic [15:0] inc_en,
  input  logic [15:0] clr_en,
  input  logic [3:0]  read_en,
  input  logic [15:0] alu_out,
  input  logic [15:0] dm_rdata,
  input  logic [15:0] im_rdata,
  output logic [15:0] bus,
  output logic [15:0] pc,
  output logic [15:0] ar,
  output logic [15:0] ir,
  output logic [15:0] ac,
  output logic [15:0] r,
  output logic [15:0] r1,
  output logic [15:0] r2,
  output logic [15:0] r3,
  output logic [15:0] r4,
  output logic [15:0] z,
  output logic        dm_we,
  output logic [15:0] dm_addr,
  output logic [15:0] dm_wdata,
  output logic [15:0] im_addr
);

  localparam int unsigned W      = 16;
  localparam int unsigned B_PC   = 1;
  localparam int unsigned B_AR   = 2;
  localparam int unsigned B_IR   = 3;
  localparam int unsigned B_AC   = 4;
  localparam int unsigned B_R    = 5;
  localparam int unsigned B_R5   = 6;
  localparam int unsigned B_R4   = 7;
  localparam int unsigned B_R3   = 8;
  localparam int unsigned B_R2   = 9;
  localparam int unsigned B_R1   = 10;
  localparam int unsigned B_DM   = 11;
  localparam int unsigned B_ALU  = 12;

  logic [W-1:0] dr;
  logic [W-1:0] pc_d, ar_d, ir_d, ac_d, r_d, r1_d, r2_d, r3_d, r4_d, dr_d;
  logic [W-1:0] r5;

  // Shared per-register update rule: clear > write > increment > hold.
  function automatic logic [W-1:0] upd(input logic [W-1:0] cur, input logic [W-1:0] d,
                                       input logic c, input logic w, input logic i);
    if (c)      return '0;
    else if (w) return d;
    else if (i) return cur + W'(1);
    else        return cur;
  endfunction

  // Bus source mux; sources are the pre-edge register values.
  always_comb begin
    bus = '0;
    case (read_en)
      4'd1:    bus = pc;
      4'd2:    bus = ar;
      4'd3:    bus = dr;
      4'd4:    bus = ir;
      4'd5:    bus = ac;
      4'd6:    bus = r;
      4'd7:    bus = r1;
      4'd8:    bus = r2;
      4'd9:    bus = r3;
      4'd10:   bus = r4;
      4'd11:   bus = r5;
      4'd12:   bus = dm_rdata;
      4'd13:   bus = im_rdata;
      default: bus = '0;
    endcase
  end

  // Next-state for every register.
  always_comb begin
    pc_d = upd(pc, bus, clr_en[B_PC], write_en[B_PC], inc_en[B_PC]);
    ar_d = upd(ar, bus, clr_en[B_AR], write_en[B_AR], inc_en[B_AR]);
    ir_d = upd(ir, bus, clr_en[B_IR], write_en[B_IR], inc_en[B_IR]);
    r_d  = upd(r,  bus, clr_en[B_R],  write_en[B_R],  inc_en[B_R]);
    r1_d = upd(r1, bus, clr_en[B_R1], write_en[B_R1], inc_en[B_R1]);
    r2_d = upd(r2, bus, clr_en[B_R2], write_en[B_R2], inc_en[B_R2]);
    r3_d = upd(r3, bus, clr_en[B_R3], write_en[B_R3], inc_en[B_R3]);
    r4_d = upd(r4, bus, clr_en[B_R4], write_en[B_R4], inc_en[B_R4]);
    // ALU load outranks a bus load when both AC write strobes are set.
    ac_d = upd(ac, write_en[B_ALU] ? alu_out : bus, clr_en[B_AC],
               write_en[B_ALU] | write_en[B_AC], inc_en[B_AC]);
    dr_d = (read_en == 4'd12) ? dm_rdata : dr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0; ar <= '0; ir <= '0; ac <= '0; r <= '0;
      r1 <= '0; r2 <= '0; r3 <= '0; r4 <= '0; dr <= '0;
    end else begin
      pc <= pc_d; ar <= ar_d; ir <= ir_d; ac <= ac_d; r <= r_d;
      r1 <= r1_d; r2 <= r2_d; r3 <= r3_d; r4 <= r4_d; dr <= dr_d;
    end
  end

`ifdef DATAPATH_R5_EN
  logic [W-1:0] r5_d;

  always_comb begin
    r5_d = upd(r5, bus, clr_en[B_R5], write_en[B_R5], inc_en[B_R5]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r5 <= '0;
    else        r5 <= r5_d;
  end

  logic unused_strobes;
  assign unused_strobes = ^{write_en[15:13], write_en[0], inc_en[15:11], inc_en[0],
                            clr_en[15:11], clr_en[0]};
`else
  // R5 absent: read code 11 yields zero and its strobes are ignored.
  assign r5 = '0;

  logic unused_strobes;
  assign unused_strobes = ^{write_en[15:13], write_en[0], inc_en[15:11], inc_en[0],
                            clr_en[15:11], clr_en[0], write_en[B_R5], inc_en[B_R5],
                            clr_en[B_R5]};
`endif

  assign z        = (ac == '0) ? W'(1) : '0;
  assign dm_we    = write_en[B_DM];
  assign dm_wdata = bus;
  assign dm_addr  = ar;
  assign im_addr  = pc;

endmodule

// File: tb/tb_datapath_regs.sv
// Self-checking bench for datapath_regs: directed scenarios plus random strobes
// checked against a register-array reference model.
module tb_datapath_regs;

`ifdef DATAPATH_R5_EN
  localparam bit R5_EN = 1'b1;
`else
  localparam bit R5_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] write_en, inc_en, clr_en;
  logic [3:0]  read_en;
  logic [15:0] alu_out, dm_rdata, im_rdata;
  logic [15:0] bus, pc, ar, ir, ac, r, r1, r2, r3, r4, z;
  logic        dm_we;
  logic [15:0] dm_addr, dm_wdata, im_addr;

  int checks   = 0;
  int failures = 0;

  // Model state indexed by strobe bit number; dr kept separately.
  logic [15:0] m [16];
  logic [15:0] m_dr;
  logic [15:0] pre_bus;

  datapath_regs dut (
    .clk(clk), .rst_n(rst_n), .write_en(write_en), .inc_en(inc_en), .clr_en(clr_en),
    .read_en(read_en), .alu_out(alu_out), .dm_rdata(dm_rdata), .im_rdata(im_rdata),
    .bus(bus), .pc(pc), .ar(ar), .ir(ir), .ac(ac), .r(r), .r1(r1), .r2(r2), .r3(r3),
    .r4(r4), .z(z), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .im_addr(im_addr)
  );

  always #5 clk = ~clk;

  task automatic check16(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_bus(input logic [3:0] code,
                                            input logic [15:0] dm, input logic [15:0] im);
    case (code)
      4'd1:  return m[1];
      4'd2:  return m[2];
      4'd3:  return m_dr;
      4'd4:  return m[3];
      4'd5:  return m[4];
      4'd6:  return m[5];
      4'd7:  return m[10];
      4'd8:  return m[9];
      4'd9:  return m[8];
      4'd10: return m[7];
      4'd11: return R5_EN ? m[6] : 16'h0000;
      4'd12: return dm;
      4'd13: return im;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m[i] = 16'h0000;
    m_dr = 16'h0000;
  endtask

  task automatic check_regs();
    check16("pc", pc, m[1]);
    check16("ar", ar, m[2]);
    check16("ir", ir, m[3]);
    check16("ac", ac, m[4]);
    check16("r",  r,  m[5]);
    check16("r4", r4, m[7]);
    check16("r3", r3, m[8]);
    check16("r2", r2, m[9]);
    check16("r1", r1, m[10]);
    check16("z",  z,  (m[4] == 16'h0000) ? 16'd1 : 16'd0);
  endtask

  // One clock: drive at negedge, check combinational outputs, then registers after the edge.
  task automatic cycle(input logic [15:0] we, input logic [15:0] ie, input logic [15:0] ce,
                       input logic [3:0] re, input logic [15:0] alu, input logic [15:0] dm,
                       input logic [15:0] im);
    logic [15:0] nm [16];
    logic [15:0] bv;
    logic        wr;
    @(negedge clk);
    write_en = we; inc_en = ie; clr_en = ce; read_en = re;
    alu_out = alu; dm_rdata = dm; im_rdata = im;
    #1;
    bv = model_bus(re, dm, im);
    pre_bus = bus;
    check16("bus", bus, bv);
    check16("dm_wdata", dm_wdata, bv);
    check16("dm_we", {15'd0, dm_we}, {15'd0, we[11]});
    check16("dm_addr", dm_addr, m[2]);
    check16("im_addr", im_addr, m[1]);
    nm = m;
    for (int b = 1; b <= 10; b++) begin
      if (b == 6 && !R5_EN) continue;
      wr = we[b] | (b == 4 && we[12]);
      if (ce[b])      nm[b] = 16'h0000;
      else if (wr)    nm[b] = (b == 4 && we[12]) ? alu : bv;
      else if (ie[b]) nm[b] = m[b] + 16'd1;
    end
    @(posedge clk);
    #1;
    m = nm;
    if (re == 4'd12) m_dr = dm;
    check_regs();
  endtask

  initial begin
    rst_n = 1'b0;
    write_en = '0; inc_en = '0; clr_en = '0; read_en = '0;
    alu_out = '0; dm_rdata = '0; im_rdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_regs();
    @(negedge clk);
    rst_n = 1'b1;

    // IR loaded from instruction memory.
    cycle(16'h0008, 16'h0, 16'h0, 4'd13, 16'h0, 16'h0, 16'h0A05);
    check16("ir_load", ir, 16'h0A05);

    // PC wrap, then clear beating write and increment.
    cycle(16'h0002, 16'h0, 16'h0, 4'd12, 16'h0, 16'hFFFF, 16'h0);
    cycle(16'h0000, 16'h0002, 16'h0, 4'd0, 16'h0, 16'h0, 16'h0);
    check16("pc_wrap", pc, 16'h0000);
    cycle(16'h0002, 16'h0, 16'h0, 4'd12, 16'h0, 16'hFFFF, 16'h0);
    cycle(16'h0002, 16'h0002, 16'h0002, 4'd12, 16'h0, 16'h1234, 16'h0);
    check16("pc_clr_wins", pc, 16'h0000);

    // ALU load beats bus load into AC.
    cycle(16'h1010, 16'h0, 16'h0, 4'd12, 16'h0007, 16'h0009, 16'h0);
    check16("ac_alu", ac, 16'h0007);
    check16("z_nonzero", z, 16'd0);

    // AC -> R1 via bus, then read R1 back.
    cycle(16'h0010, 16'h0, 16'h0, 4'd12, 16'h0, 16'h0055, 16'h0);
    cycle(16'h0400, 16'h0, 16'h0, 4'd5, 16'h0, 16'h0, 16'h0);
    cycle(16'h0000, 16'h0, 16'h0, 4'd7, 16'h0, 16'h0, 16'h0);
    check16("r1_val", r1, 16'h0055);
    check16("r1_bus", pre_bus, 16'h0055);

    // R5 write and read back.
    cycle(16'h0040, 16'h0, 16'h0, 4'd12, 16'h0, 16'hBEEF, 16'h0);
    cycle(16'h0000, 16'h0, 16'h0, 4'd11, 16'h0, 16'h0, 16'h0);
    check16("r5_bus", pre_bus, R5_EN ? 16'hBEEF : 16'h0000);

    // Same register read and written: old value stays.
    cycle(16'h0010, 16'h0010, 16'h0, 4'd5, 16'h0, 16'h0, 16'h0);
    check16("ac_self", ac, 16'h0055);

    // Async reset mid-cycle with AC=1234; strobes during reset are discarded.
    cycle(16'h0010, 16'h0, 16'h0, 4'd12, 16'h0, 16'h1234, 16'h0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_regs();
    check16("rst_z", z, 16'd1);
    write_en = 16'hFFFF; inc_en = 16'hFFFF; read_en = 4'd3; dm_rdata = 16'h5A5A;
    #1;
    check16("rst_dr", bus, 16'h0000);
    @(posedge clk);
    #1;
    check_regs();
    @(negedge clk);
    rst_n = 1'b1;
    write_en = '0; inc_en = '0;

    // Random strobes, sparse so registers live a while.
    for (int n = 0; n < 3000; n++) begin
      cycle(16'($urandom) & 16'($urandom),
            16'($urandom) & 16'($urandom),
            16'($urandom) & 16'($urandom) & 16'($urandom) & 16'($urandom),
            4'($urandom), 16'($urandom),
            (n % 7 == 0) ? 16'h0000 : 16'($urandom),
            (n % 11 == 0) ? 16'hFFFF : 16'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
